serial_comparator_n_bits: RTL and testbench

Parametrised sequential magnitude comparator for WIDTH-bit operands, evaluated MSB-first, CHUNK bits per clock. Generalises the 4-bit combinational EQUAL/LESS/HIGHER comparator to wide operands without a long combinational carry chain. Adds a start/done handshake, a signed/unsigned mode and optional early termination. It sits between operand registers and control logic that needs a registered three-way compare result.

---
 rtl/serial_comparator_n_bits_pkg.sv | 28 ++
 rtl/serial_comparator_n_bits_if.sv | 31 +++
 rtl/serial_comparator_n_bits_chunk.sv | 16 +
 rtl/serial_comparator_n_bits.sv | 146 ++++++++++++++
 tb/tb_serial_comparator_n_bits.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/serial_comparator_n_bits_pkg.sv
// Shared constants for the serial magnitude comparator: FSM encodings and
// the bit ordering of the {HIGHER, LESS, EQUAL} result flags.
package serial_comparator_n_bits_pkg;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COMPARE = 1'b1;

    localparam int FLAG_EQ_BIT = 0;
    localparam int FLAG_LT_BIT = 1;
    localparam int FLAG_GT_BIT = 2;

    typedef logic [2:0] cmp_flags_t;

    // Exactly one flag is set; no recorded difference means equal.
    function automatic cmp_flags_t make_flags(input logic lt, input logic gt);
        cmp_flags_t f;
        f = 3'b000;
        if (gt) begin
            f[FLAG_GT_BIT] = 1'b1;
        end else if (lt) begin
            f[FLAG_LT_BIT] = 1'b1;
        end else begin
            f[FLAG_EQ_BIT] = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/serial_comparator_n_bits_if.sv
// Request/result bundle between the operand owner (master) and the
// serial comparator (slave).
interface serial_comparator_n_bits_if #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] port_a;
    logic [WIDTH-1:0] port_b;
    logic             busy;
    logic             done;
    logic             equal;
    logic             less;
    logic             higher;
    logic [CW-1:0]    cycles;

    modport master (
        output start, signed_mode, port_a, port_b,
        input  busy, done, equal, less, higher, cycles
    );

    modport slave (
        input  start, signed_mode, port_a, port_b,
        output busy, done, equal, less, higher, cycles
    );

endinterface

// File: rtl/serial_comparator_n_bits_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module serial_comparator_n_bits_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             eq_o,
    output logic             lt_o,
    output logic             gt_o
);

    assign eq_o = (a_i == b_i);
    assign lt_o = (a_i <  b_i);
    assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/serial_comparator_n_bits.sv
// MSB-first multi-cycle three-way comparator; one CHUNK-bit slice per clock,
// optional early exit at the first differing slice, signed or unsigned.
module serial_comparator_n_bits
    import serial_comparator_n_bits_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    serial_comparator_n_bits_if.slave  cmp_if
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    logic [0:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [IW-1:0]    idx_q,    idx_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             rec_lt_q, rec_lt_d;
    logic             rec_gt_q, rec_gt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    cmp_flags_t       flags_q,  flags_d;
    logic [CW-1:0]    cycles_q, cycles_d;

    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic             ch_eq_s;
    logic             ch_lt_s;
    logic             ch_gt_s;
    logic             lt_s;
    logic             gt_s;
    logic             finish_s;

    assign a_chunk_s = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign b_chunk_s = b_q[int'(idx_q) * CHUNK +: CHUNK];

    serial_comparator_n_bits_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i  (a_chunk_s),
        .b_i  (b_chunk_s),
        .eq_o (ch_eq_s),
        .lt_o (ch_lt_s),
        .gt_o (ch_gt_s)
    );

    // The first differing chunk decides; later chunks never overwrite it.
    assign lt_s     = (rec_lt_q | rec_gt_q) ? rec_lt_q : ch_lt_s;
    assign gt_s     = (rec_lt_q | rec_gt_q) ? rec_gt_q : ch_gt_s;
    assign finish_s = ((EARLY_EXIT != 0) && (lt_s || gt_s)) || (idx_q == IW'(0));

    // Next-state logic for the FSM, operand registers and result registers.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rec_lt_d = rec_lt_q;
        rec_gt_d = rec_gt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        flags_d  = flags_q;
        cycles_d = cycles_q;
        case (state_q)
            ST_IDLE: begin
                if (cmp_if.start) begin
                    // Flipping both MSBs maps two's complement onto offset
                    // binary, so the unsigned chunk compare stays correct.
                    a_d      = cmp_if.port_a ^ (cmp_if.signed_mode ? MSB_MASK : '0);
                    b_d      = cmp_if.port_b ^ (cmp_if.signed_mode ? MSB_MASK : '0);
                    idx_d    = IW'(NCHUNK - 1);
                    cnt_d    = '0;
                    rec_lt_d = 1'b0;
                    rec_gt_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_COMPARE;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            ST_COMPARE: begin
                cnt_d    = cnt_q + CW'(1);
                rec_lt_d = lt_s;
                rec_gt_d = gt_s;
                if (finish_s) begin
                    flags_d  = make_flags(lt_s, gt_s);
                    cycles_d = cnt_q + CW'(1);
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    idx_d    = idx_q - IW'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rec_lt_q <= 1'b0;
            rec_gt_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            flags_q  <= 3'b000;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rec_lt_q <= rec_lt_d;
            rec_gt_q <= rec_gt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            flags_q  <= flags_d;
            cycles_q <= cycles_d;
        end
    end

    assign cmp_if.busy   = busy_q;
    assign cmp_if.done   = done_q;
    assign cmp_if.equal  = flags_q[FLAG_EQ_BIT];
    assign cmp_if.less   = flags_q[FLAG_LT_BIT];
    assign cmp_if.higher = flags_q[FLAG_GT_BIT];
    assign cmp_if.cycles = cycles_q;

endmodule

// File: tb/tb_serial_comparator_n_bits.sv
// Scoreboard bench: two comparators (early exit on / off) with a reference
// model of the three-way compare, its chunk count and START->DONE latency.
module tb_serial_comparator_n_bits;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    typedef struct {
        logic [2:0] flags;       // {higher, less, equal}
        int         cyc;
        int         start_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q_ee[$];
    exp_t q_full[$];
    exp_t e_ee;
    exp_t e_full;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_comparator_n_bits_if #(.WIDTH(WIDTH), .CHUNK(CHUNK)) ifa ();
    serial_comparator_n_bits_if #(.WIDTH(WIDTH), .CHUNK(CHUNK)) ifb ();

    serial_comparator_n_bits #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1)) dut_ee (
        .clk_i  (clk),
        .rst_i  (rst),
        .cmp_if (ifa)
    );

    serial_comparator_n_bits #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(0)) dut_full (
        .clk_i  (clk),
        .rst_i  (rst),
        .cmp_if (ifb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sm, input bit early);
        exp_t e;
        int   pos;
        logic lt;
        logic gt;
        pos = 0;
        for (int c = NCHUNK - 1; c >= 0; c--) begin
            if (pos == 0 && a[c*CHUNK +: CHUNK] != b[c*CHUNK +: CHUNK]) pos = NCHUNK - c;
        end
        lt = sm ? ($signed(a) < $signed(b)) : (a < b);
        gt = sm ? ($signed(a) > $signed(b)) : (a > b);
        e.flags      = {gt, lt, ~(gt | lt)};
        e.cyc        = (early && pos != 0) ? pos : NCHUNK;
        e.start_edge = 0;
        return e;
    endfunction

    task automatic score(input string tag, input exp_t e, input logic [2:0] flags,
                         input logic [2:0] cycles, input logic busy, input int now);
        check({tag, "_flags"},   {29'd0, flags},  {29'd0, e.flags});
        check({tag, "_cycles"},  {29'd0, cycles}, e.cyc);
        check({tag, "_latency"}, now - e.start_edge, e.cyc);
        check({tag, "_busy"},    {31'd0, busy},   32'd0);
    endtask

    always @(negedge clk) begin
        if (ifa.done) begin
            if (q_ee.size() == 0) begin
                check("ee_unexpected_done", {31'd0, ifa.done}, 32'd0);
            end else begin
                e_ee = q_ee.pop_front();
                score("ee", e_ee, {ifa.higher, ifa.less, ifa.equal}, ifa.cycles, ifa.busy, cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.done) begin
            if (q_full.size() == 0) begin
                check("full_unexpected_done", {31'd0, ifb.done}, 32'd0);
            end else begin
                e_full = q_full.pop_front();
                score("full", e_full, {ifb.higher, ifb.less, ifb.equal}, ifb.cycles, ifb.busy, cyc);
            end
        end
    end

    // Called at a falling edge; START is high across exactly one rising edge.
    task automatic issue(input bit full, input logic [15:0] a, input logic [15:0] b,
                         input logic sm, input bit push);
        exp_t e;
        e = model(a, b, sm, !full);
        e.start_edge = cyc + 1;
        if (!full) begin
            ifa.start = 1'b1; ifa.port_a = a; ifa.port_b = b; ifa.signed_mode = sm;
            if (push) q_ee.push_back(e);
        end else begin
            ifb.start = 1'b1; ifb.port_a = a; ifb.port_b = b; ifb.signed_mode = sm;
            if (push) q_full.push_back(e);
        end
        @(negedge clk);
        if (!full) begin
            ifa.start = 1'b0;
            if (push) check("ee_busy_after_start", {31'd0, ifa.busy}, 32'd1);
        end else begin
            ifb.start = 1'b0;
            if (push) check("full_busy_after_start", {31'd0, ifb.busy}, 32'd1);
        end
    endtask

    task automatic wait_idle(input bit full);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!full && !ifa.busy && q_ee.size() == 0) break;
            if (full && !ifb.busy && q_full.size() == 0) break;
        end
        if (!full) check("ee_idle_timeout", q_ee.size(), 32'd0);
        else       check("full_idle_timeout", q_full.size(), 32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rsm;
        ifa.start = 1'b0; ifa.signed_mode = 1'b0; ifa.port_a = 16'h0000; ifa.port_b = 16'h0000;
        ifb.start = 1'b0; ifb.signed_mode = 1'b0; ifb.port_a = 16'h0000; ifb.port_b = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ee_reset_outputs",   {ifa.busy, ifa.done, ifa.equal, ifa.less, ifa.higher, ifa.cycles}, 32'd0);
        check("full_reset_outputs", {ifb.busy, ifb.done, ifb.equal, ifb.less, ifb.higher, ifb.cycles}, 32'd0);

        issue(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1); wait_idle(1'b0);
        issue(1'b0, 16'h5000, 16'h0000, 1'b0, 1'b1); wait_idle(1'b0);
        issue(1'b1, 16'h5000, 16'h0000, 1'b0, 1'b1); wait_idle(1'b1);
        issue(1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b1); wait_idle(1'b0);
        issue(1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1); wait_idle(1'b0);
        issue(1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b1); wait_idle(1'b0);

        // Restart in the DONE cycle.
        issue(1'b0, 16'h1230, 16'h1231, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) begin
            if (ifa.done) break;
            @(negedge clk);
        end
        check("restart_done_seen", {31'd0, ifa.done}, 32'd1);
        issue(1'b0, 16'h0011, 16'h0011, 1'b0, 1'b1); wait_idle(1'b0);

        // START while busy is ignored.
        issue(1'b0, 16'h00A0, 16'h00B0, 1'b0, 1'b1);
        issue(1'b0, 16'hF000, 16'h0000, 1'b0, 1'b0);
        wait_idle(1'b0);
        repeat (4) @(negedge clk);

        // Reset on the second COMPARE edge aborts without DONE.
        issue(1'b0, 16'h1111, 16'h1112, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", {ifa.busy, ifa.done, ifa.equal, ifa.less, ifa.higher, ifa.cycles}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        issue(1'b0, 16'h1111, 16'h1112, 1'b0, 1'b1); wait_idle(1'b0);

        for (int n = 0; n < 24; n++) begin
            ra  = 16'($urandom);
            rb  = (n % 3 == 0) ? ra : ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
            if (n % 5 == 4) rb = 16'($urandom);
            rsm = 1'($urandom_range(0, 1));
            issue(1'b0, ra, rb, rsm, 1'b1); wait_idle(1'b0);
            issue(1'b1, ra, rb, rsm, 1'b1); wait_idle(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
